// File: rtl/piano_tone_scheduler.sv
`timescale 1ns/1ps
// piano_tone_scheduler
// Monophonic voice scheduler: conditions the 13 raw key inputs (C5..C6),
// picks one note with last-note priority, and drives a single square-wave
// generator whose half-period divisor only changes on tone_out edges.
//
// Handshake: there is no valid/ready pair here. note_valid is a level that
// qualifies note_idx; it is consumed by the generator without back-pressure,
// and note_idx keeps its last value while note_valid is low.
module piano_tone_scheduler #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] keys,
  input  logic [1:0]  octave,
  output logic        tone_out,
  output logic        playing,
  output logic [3:0]  note_idx,
  output logic        note_valid
);

  // ---------------------------------------------------------------------
  // Divisor table: half-period in clk cycles, CLK_HZ/(2*f) truncated.
  // ---------------------------------------------------------------------
  localparam logic [25:0] DIV_C5  = 26'(CLK_HZ / (2 * 523));
  localparam logic [25:0] DIV_CS5 = 26'(CLK_HZ / (2 * 554));
  localparam logic [25:0] DIV_D5  = 26'(CLK_HZ / (2 * 587));
  localparam logic [25:0] DIV_DS5 = 26'(CLK_HZ / (2 * 622));
  localparam logic [25:0] DIV_E5  = 26'(CLK_HZ / (2 * 659));
  localparam logic [25:0] DIV_F5  = 26'(CLK_HZ / (2 * 698));
  localparam logic [25:0] DIV_FS5 = 26'(CLK_HZ / (2 * 740));
  localparam logic [25:0] DIV_G5  = 26'(CLK_HZ / (2 * 784));
  localparam logic [25:0] DIV_GS5 = 26'(CLK_HZ / (2 * 831));
  localparam logic [25:0] DIV_A5  = 26'(CLK_HZ / (2 * 880));
  localparam logic [25:0] DIV_AS5 = 26'(CLK_HZ / (2 * 932));
  localparam logic [25:0] DIV_B5  = 26'(CLK_HZ / (2 * 988));
  localparam logic [25:0] DIV_C6  = 26'(CLK_HZ / (2 * 1047));

  // Tick counter width; a one-cycle debounce period still needs one bit.
  localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    GEN_IDLE  = 2'd0,
    GEN_PLAY  = 2'd1,
    GEN_DRAIN = 2'd2
  } gen_state_t;

  // Highest set bit of a 13-bit key vector (0 when empty).
  function automatic logic [3:0] top_bit(input logic [12:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [12:0]   key_s1, key_s2;
  logic [12:0]   samp;
  logic [12:0]   db;
  logic [12:0]   db_next;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  // Two-flop synchronizer for the asynchronous key levels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= keys;
      key_s2 <= key_s1;
    end
  end

  // Free-running sample-period counter; tick is its terminal count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A bit follows the new sample only when it matches the previous sample;
  // disagreeing bits keep their debounced value.
  always_comb begin
    db_next = db;
    if (tick) begin
      db_next = (samp & key_s2) | (db & (samp ^ key_s2));
    end
  end

  // Sample register and debounced key state, both advanced on tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      samp <= '0;
      db   <= '0;
    end else if (tick) begin
      samp <= key_s2;
      db   <= db_next;
    end
  end

  // ---------------------------------------------------------------------
  // Last-note-priority arbitration (evaluated on tick only)
  // ---------------------------------------------------------------------
  logic [12:0] rise;
  logic [15:0] db_ext;
  logic [3:0]  sel_next;
  logic        valid_next;

  assign rise   = db_next & ~db;
  assign db_ext = {3'b000, db_next};

  // A fresh press always wins; otherwise keep the held note, else fall back
  // to the highest key still down.
  always_comb begin
    sel_next   = note_idx;
    valid_next = note_valid;
    if (tick) begin
      if (rise != 13'd0) begin
        sel_next   = top_bit(rise);
        valid_next = 1'b1;
      end else if (note_valid && db_ext[note_idx]) begin
        valid_next = 1'b1;
      end else if (db_next != 13'd0) begin
        sel_next   = top_bit(db_next);
        valid_next = 1'b1;
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  // Registered selection outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      note_idx   <= 4'd0;
      note_valid <= 1'b0;
    end else begin
      note_idx   <= sel_next;
      note_valid <= valid_next;
    end
  end

  // ---------------------------------------------------------------------
  // Divisor lookup for the current note and octave
  // ---------------------------------------------------------------------
  logic [25:0] base_sel;
  logic [25:0] div_sel;

  // Table lookup followed by the octave shift (3 behaves like 0).
  always_comb begin
    base_sel = DIV_C5;
    case (note_idx)
      4'd0:    base_sel = DIV_C5;
      4'd1:    base_sel = DIV_CS5;
      4'd2:    base_sel = DIV_D5;
      4'd3:    base_sel = DIV_DS5;
      4'd4:    base_sel = DIV_E5;
      4'd5:    base_sel = DIV_F5;
      4'd6:    base_sel = DIV_FS5;
      4'd7:    base_sel = DIV_G5;
      4'd8:    base_sel = DIV_GS5;
      4'd9:    base_sel = DIV_A5;
      4'd10:   base_sel = DIV_AS5;
      4'd11:   base_sel = DIV_B5;
      4'd12:   base_sel = DIV_C6;
      default: base_sel = DIV_C5;
    endcase
    div_sel = base_sel;
    case (octave)
      2'd1:    div_sel = base_sel >> 1;
      2'd2:    div_sel = base_sel << 1;
      default: div_sel = base_sel;
    endcase
  end

  // ---------------------------------------------------------------------
  // Tone generator FSM
  // ---------------------------------------------------------------------
  gen_state_t  state, state_next;
  logic [25:0] cnt, cnt_next;
  logic [25:0] div_a, div_a_next;
  logic        tone_next;
  logic        half_end;

  assign half_end = (cnt == div_a - 26'd1);
  assign playing  = (state != GEN_IDLE);

  // Generator state, half-period counter, active divisor and pin.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= GEN_IDLE;
      cnt      <= 26'd0;
      div_a    <= 26'd0;
      tone_out <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      div_a    <= div_a_next;
      tone_out <= tone_next;
    end
  end

  // Next-state logic: the divisor is reloaded only at a half-period end,
  // and a high phase is never cut short when the note is released.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_a_next = div_a;
    tone_next  = tone_out;
    case (state)
      GEN_IDLE: begin
        tone_next = 1'b0;
        cnt_next  = 26'd0;
        if (note_valid) begin
          div_a_next = div_sel;
          tone_next  = 1'b1;
          state_next = GEN_PLAY;
        end
      end
      GEN_PLAY: begin
        if (half_end) begin
          tone_next  = ~tone_out;
          cnt_next   = 26'd0;
          div_a_next = div_sel;
          if (!note_valid && tone_out) state_next = GEN_IDLE;
        end else begin
          cnt_next = cnt + 26'd1;
          if (!note_valid && tone_out) state_next = GEN_DRAIN;
        end
      end
      GEN_DRAIN: begin
        if (half_end) begin
          tone_next  = 1'b0;
          cnt_next   = 26'd0;
          state_next = GEN_IDLE;
        end else begin
          cnt_next = cnt + 26'd1;
          if (note_valid) state_next = GEN_PLAY;
        end
      end
      default: begin
        state_next = GEN_IDLE;
        tone_next  = 1'b0;
        cnt_next   = 26'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_piano_tone_scheduler.sv
`timescale 1ns/1ps
// Bench for piano_tone_scheduler. The clock frequency parameter is scaled
// down so that every half-period is tens of cycles instead of tens of
// thousands; the divisor arithmetic is the same at any CLK_HZ.
module tb_piano_tone_scheduler;

  localparam int CLK_HZ = 100000;
  localparam int DEB    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] keys = '0;
  logic [1:0]  octave = 2'd0;
  logic        tone_out;
  logic        playing;
  logic [3:0]  note_idx;
  logic        note_valid;

  always #5 clk = ~clk;

  piano_tone_scheduler #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys(keys),
    .octave(octave),
    .tone_out(tone_out),
    .playing(playing),
    .note_idx(note_idx),
    .note_valid(note_valid)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int freq_hz [13] = '{523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988, 1047};

  // Reference model of the selection (event level, not tick level).
  logic [12:0] m_held  = '0;
  int          m_sel   = 0;
  logic        m_valid = 1'b0;

  // Expected half-periods queued by directed sections.
  logic [31:0] exp_q [$];

  // Tone monitor state.
  logic        prev_tone = 1'b0;
  logic [3:0]  prev_idx  = 4'd0;
  logic [1:0]  prev_oct  = 2'd0;
  int          phase_len = 0;
  int          phase_exp = 0;
  bit          timed     = 1'b0;
  int          edge_count = 0;
  int          last_len  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int idx, input logic [1:0] oct);
    int b;
    b = CLK_HZ / (2 * freq_hz[idx]);
    if (oct == 2'd1) return b / 2;
    if (oct == 2'd2) return b * 2;
    return b;
  endfunction

  function automatic int top_bit(input logic [12:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 13; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Last-note priority applied to one change of the held key set.
  task automatic model_update(input logic [12:0] nk);
    logic [12:0] rs;
    rs = nk & ~m_held;
    if (rs != 13'd0) begin
      m_sel = top_bit(rs);
      m_valid = 1'b1;
    end else if (m_valid && nk[m_sel]) begin
      m_valid = 1'b1;
    end else if (nk != 13'd0) begin
      m_sel = top_bit(nk);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    m_held = nk;
  endtask

  // Every timed half-period must equal the divisor chosen at its start edge.
  always @(negedge clk) begin
    if (tone_out) check("playing_when_high", {31'b0, playing}, 32'd1);
    if (!reset) begin
      timed = 1'b0;
    end else if (tone_out != prev_tone) begin
      if (timed) begin
        check("half_period", phase_len, phase_exp);
        last_len = phase_len;
      end
      phase_exp = div_of(int'(prev_idx), prev_oct);
      phase_len = 1;
      timed = playing;
      edge_count++;
    end else begin
      phase_len++;
      if (!playing) timed = 1'b0;
    end
    prev_tone = tone_out;
    prev_idx  = note_idx;
    prev_oct  = octave;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_keys(input logic [12:0] nk);
    @(posedge clk); #1;
    keys = nk;
    model_update(nk);
    repeat (16) @(negedge clk);
    check("note_valid", {31'b0, note_valid}, {31'b0, m_valid});
    check("note_idx", {28'b0, note_idx}, 32'(m_sel));
  endtask

  task automatic set_octave(input logic [1:0] o);
    @(posedge clk); #1;
    octave = o;
  endtask

  task automatic wait_edge();
    int start;
    start = edge_count;
    for (int i = 0; i < 600 && edge_count == start; i++) @(negedge clk);
    if (edge_count == start) check("edge_timeout", 32'd0, 32'd1);
  endtask

  // Pop queued expected half-periods, one per tone edge.
  task automatic check_queued_phases();
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_edge();
      check("directed_half", last_len, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [12:0] nk;
    int r, b, cyc;
    bit got;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tone", {31'b0, tone_out}, 32'd0);
    check("rst_playing", {31'b0, playing}, 32'd0);
    check("rst_note_idx", {28'b0, note_idx}, 32'd0);
    check("rst_note_valid", {31'b0, note_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single key, base octave: both phases at C#5 divisor
    apply_keys(13'b0_0000_0000_0010);
    exp_q.push_back(div_of(1, 2'd0));
    exp_q.push_back(div_of(1, 2'd0));
    exp_q.push_back(div_of(1, 2'd0));
    check_queued_phases();

    // Hold C5, then add G5: old half completes, then G5 divisor
    apply_keys(13'b0_0000_0000_0001);
    wait_edge();
    wait_edge();
    apply_keys(13'b0_0000_1000_0001);
    exp_q.push_back(div_of(0, 2'd0));
    exp_q.push_back(div_of(7, 2'd0));
    exp_q.push_back(div_of(7, 2'd0));
    check_queued_phases();

    // Release G5 while C5 still held: back to C5
    wait_edge();
    apply_keys(13'b0_0000_0000_0001);
    exp_q.push_back(div_of(7, 2'd0));
    exp_q.push_back(div_of(0, 2'd0));
    check_queued_phases();

    // A5 one octave up, then octave code 3 (base)
    set_octave(2'd1);
    apply_keys(13'b0_0010_0000_0000);
    wait_edge();
    wait_edge();
    exp_q.push_back(div_of(9, 2'd1));
    exp_q.push_back(div_of(9, 2'd1));
    check_queued_phases();
    set_octave(2'd3);
    wait_edge();
    wait_edge();
    exp_q.push_back(div_of(9, 2'd0));
    check_queued_phases();

    // Release everything just after a rising edge: high phase completes
    wait_edge();
    if (!tone_out) wait_edge();
    check("pre_release_high", {31'b0, tone_out}, 32'd1);
    @(posedge clk); #1;
    keys = '0;
    model_update('0);
    wait_edge();
    check("drain_len", last_len, div_of(9, 2'd0));
    check("drain_tone_low", {31'b0, tone_out}, 32'd0);
    check("drain_idle", {31'b0, playing}, 32'd0);
    repeat (20) @(negedge clk);
    check("rest_tone", {31'b0, tone_out}, 32'd0);
    check("rest_playing", {31'b0, playing}, 32'd0);
    check("rest_valid", {31'b0, note_valid}, 32'd0);
    check("rest_idx_holds", {28'b0, note_idx}, 32'(m_sel));

    // 3-cycle glitch on E5 must not register
    @(posedge clk); #1;
    keys = 13'b0_0000_0001_0000;
    repeat (3) @(posedge clk);
    #1;
    keys = '0;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (note_valid) cyc++;
    end
    check("glitch_valid_cycles", cyc, 32'd0);

    // Randomized key/octave activity; the tone monitor checks every phase
    set_octave(2'd0);
    for (int e = 0; e < 40; e++) begin
      r = $urandom_range(0, 9);
      b = $urandom_range(0, 12);
      if (r <= 1)      nk = '0;
      else if (r <= 5) nk = m_held | (13'd1 << b);
      else if (r <= 8) nk = m_held & ~(13'd1 << b);
      else             nk = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 3) == 0) set_octave(2'($urandom_range(0, 3)));
      apply_keys(nk);
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end

    // Reset pulse mid-note, then reacquire the held key
    set_octave(2'd0);
    apply_keys(13'b0_0000_0010_0000);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (tone_out && playing) got = 1'b1;
    end
    check("pre_reset_high", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tone", {31'b0, tone_out}, 32'd0);
    check("mid_rst_playing", {31'b0, playing}, 32'd0);
    check("mid_rst_valid", {31'b0, note_valid}, 32'd0);
    check("mid_rst_idx", {28'b0, note_idx}, 32'd0);
    m_held = '0;
    m_valid = 1'b0;
    m_sel = 0;
    model_update(keys);
    got = 1'b0;
    for (int i = 1; i < 13 && !got; i++) begin
      @(negedge clk);
      if (note_valid) got = 1'b1;
    end
    check("reacquire_in_time", {31'b0, got}, 32'd1);
    check("reacquire_idx", {28'b0, note_idx}, 32'(m_sel));
    exp_q.push_back(div_of(5, 2'd0));
    exp_q.push_back(div_of(5, 2'd0));
    wait_edge();
    check_queued_phases();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global bound on run length
  initial begin
    repeat (60000) @(posedge clk);
    check("watchdog", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
